txt_render: RTL

TXT_RENDER -- requirements
Module: txt_render

---
 rtl/txt_render.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/txt_render.sv
// Character-cell text renderer: walks a text page, looks up glyph rows and
// writes one framebuffer pixel per accepted cycle, scan line by scan line.
module txt_render #(
    parameter int unsigned      COLS      = 40,
    parameter int unsigned      ROWS      = 24,
    parameter int unsigned      GW        = 7,
    parameter int unsigned      GH        = 8,
    parameter int unsigned      PIX_W     = 24,
    parameter int unsigned      FB_AW     = 16,
    parameter int unsigned      TXT_AW    = 16,
    parameter int unsigned      TXT_BASE  = 'h400,
    parameter bit               APPLE_IL  = 1'b1,
    parameter bit               ATTR_EN   = 1'b1,
    parameter logic [PIX_W-1:0] FG        = 24'hffffff,
    parameter logic [PIX_W-1:0] BG        = 24'h000000,
    parameter int unsigned      FLASH_DIV = 16
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [TXT_AW-1:0]       txt_adr,
    input  logic [7:0]              txt_q,
    output logic [7+$clog2(GH):0]   crom_adr,
    input  logic [7:0]              crom_q,
    output logic                    fb_we,
    output logic [FB_AW-1:0]        fb_adr,
    output logic [PIX_W-1:0]        fb_d,
    input  logic                    fb_ready
);

    localparam int unsigned LB  = $clog2(GH);
    localparam int unsigned CRW = 8 + LB;
    localparam int unsigned CW  = $clog2(COLS + 1);
    localparam int unsigned YW  = $clog2(ROWS * GH + 1);
    localparam int unsigned XW  = $clog2(GW + 1);
    localparam int unsigned FW  = $clog2(FLASH_DIV + 1);

    typedef enum logic [2:0] {IDLE, TADR, CHR, GLY, PIX} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  col;
    logic [YW-1:0]  y;
    logic [XW-1:0]  c;
    logic [1:0]     attr;
    logic [7:0]     glyph;
    logic           flash_phase;
    logic [FW-1:0]  frame_cnt;

    logic           last_c, last_col, last_y, accept, frame_end;
    logic           inv, pix_bit;
    logic [2:0]     bit_idx;
    logic [31:0]    row_i;

    assign last_c    = (32'(c) == GW - 1);
    assign last_col  = (32'(col) == COLS - 1);
    assign last_y    = (32'(y) == ROWS * GH - 1);
    assign accept    = (state == PIX) && fb_ready;
    assign frame_end = accept && last_c && last_col && last_y;
    assign bit_idx   = 3'(GW - 1 - 32'(c));
    assign pix_bit   = glyph[bit_idx];
    assign row_i     = 32'(y) >> LB;

    always_comb begin
        inv = 1'b0;
        if (ATTR_EN) begin
            case (attr)
                2'b00:   inv = 1'b1;
                2'b01:   inv = flash_phase;
                default: inv = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        txt_adr   = '0;
        crom_adr  = '0;
        fb_we     = 1'b0;
        fb_adr    = '0;
        fb_d      = BG;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = TADR;
            end
            TADR: begin
                if (APPLE_IL)
                    txt_adr = TXT_AW'(TXT_BASE + 128 * (row_i % 8) + 40 * (row_i / 8) + 32'(col));
                else
                    txt_adr = TXT_AW'(TXT_BASE + row_i * COLS + 32'(col));
                state_nxt = CHR;
            end
            CHR: begin
                // Glyph ROM is addressed straight from the text read so its data lands in GLY.
                crom_adr  = (CRW'(txt_q) << LB) | CRW'(32'(y) % GH);
                state_nxt = GLY;
            end
            GLY: state_nxt = PIX;
            PIX: begin
                fb_we  = 1'b1;
                fb_adr = FB_AW'(32'(col) * GW + 32'(c) + 32'(y) * (COLS * GW));
                fb_d   = (pix_bit ^ inv) ? FG : BG;
                if (accept && last_c) state_nxt = (last_col && last_y) ? IDLE : TADR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            col         <= '0;
            y           <= '0;
            c           <= '0;
            attr        <= '0;
            glyph       <= '0;
            done        <= 1'b0;
            flash_phase <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            done <= frame_end;
            if (state == IDLE && start) begin
                col <= '0;
                y   <= '0;
                c   <= '0;
            end
            if (state == CHR) attr  <= txt_q[7:6];
            if (state == GLY) glyph <= crom_q;
            if (accept) begin
                if (!last_c) begin
                    c <= c + 1'b1;
                end else begin
                    c <= '0;
                    if (!last_col) begin
                        col <= col + 1'b1;
                    end else begin
                        col <= '0;
                        y   <= last_y ? '0 : y + 1'b1;
                    end
                end
            end
            if (frame_end) begin
                if (32'(frame_cnt) == FLASH_DIV - 1) begin
                    frame_cnt   <= '0;
                    flash_phase <= ~flash_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule
